// File: rtl/mips_register_file.sv
// 32-entry MIPS general-purpose register file: two combinational read ports with
// write-first bypass, one clocked write-back port, and a raw-storage debug read port.
module mips_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  output logic [DATA_WIDTH-1:0] read_data_a,
  output logic [DATA_WIDTH-1:0] read_data_b,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [DATA_WIDTH-1:0] debug_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];

  logic w_write_ok;
  logic w_bypass_a;
  logic w_bypass_b;

  // A write to r0 is architecturally meaningless, so it never qualifies as a write.
  assign w_write_ok = write_en && (write_addr != '0);
  assign w_bypass_a = w_write_ok && (write_addr == read_addr_a);
  assign w_bypass_b = w_write_ok && (write_addr == read_addr_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_write_ok) begin
      r_regs[write_addr] <= write_data;
    end
  end

  // Reset dominates the read ports, then the r0 rule, then the same-cycle bypass.
  assign read_data_a = rst                  ? '0 :
                       (read_addr_a == '0)  ? '0 :
                       w_bypass_a           ? write_data :
                                              r_regs[read_addr_a];

  assign read_data_b = rst                  ? '0 :
                       (read_addr_b == '0)  ? '0 :
                       w_bypass_b           ? write_data :
                                              r_regs[read_addr_b];

  assign debug_data  = (debug_addr == '0) ? '0 : r_regs[debug_addr];

endmodule

// File: doc/mips_register_file.md
Name: mips_register_file

Overview:
- 32-entry general-purpose register file for the single-cycle MIPS datapath.
- Sits directly upstream of the ALU: read port A drives ALU input_a, read port B drives the input_b mux.
- Consumes the ALU result (or memory load data) through the single write-back port.
- Reads are combinational so a full instruction completes in one cycle; writes are clocked.

Parameters:
DATA_WIDTH, 32, register and data-bus width in bits
ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH (32)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
read_addr_a  input  ADDR_WIDTH  rs index, read port A
read_addr_b  input  ADDR_WIDTH  rt index, read port B
read_data_a  output DATA_WIDTH  contents of read_addr_a, to ALU input_a
read_data_b  output DATA_WIDTH  contents of read_addr_b, to ALU input_b mux
write_en     input  1  write-back enable (RegWrite)
write_addr   input  ADDR_WIDTH  destination index (rt or rd after RegDst mux)
write_data   input  DATA_WIDTH  write-back value (ALU result or load data)
debug_addr   input  ADDR_WIDTH  testbench/debug read index
debug_data   output DATA_WIDTH  contents of debug_addr; raw storage, no bypass

Behaviour:
- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits. Entry 0 is hardwired to zero.
- Reset:
  - On a rising clk edge with rst=1, all entries are cleared to 0 in that single cycle.
  - Writes presented in that cycle are discarded.
- Reset outputs:
  - While rst=1, read_data_a and read_data_b are forced to 0.
  - debug_data shows storage as-is, so it is 0 from the cycle after the reset edge onward.
- Write:
  - On a rising clk edge with rst=0, write_en=1 and write_addr!=0, entry[write_addr] <= write_data.
  - write_addr=0 is a silent no-op; entry 0 stays 0.
  - write_en=0 leaves all entries unchanged.
- Read:
  - Combinational, zero-cycle latency: read_data_x = entry[read_addr_x].
  - read_addr_x=0 always returns 0, regardless of write activity.
- Write-first bypass (rst=0):
  - If write_en=1, write_addr!=0 and write_addr==read_addr_x, then read_data_x = write_data in the same cycle, before the edge.
  - Both ports bypass independently; both may hit the same address simultaneously.
- Simultaneous events:
  - read_addr_a==read_addr_b returns identical data on both ports.
  - rst=1 with write_en=1: reset wins, no write occurs, no bypass.
- Reset mid-operation: any pending write in the reset cycle is lost. The next cycle's reads return 0 for every entry.
- No X propagation: all outputs are defined for every address value. Full decode, no out-of-range indices exist.
- Implementation:
  - Storage is a flip-flop array with synchronous clear.
  - Do not infer a RAM macro; the synchronous clear-all and dual combinational reads preclude it.

Test Plan:
- Reset clears storage: write 0xDEADBEEF to r5, assert rst for 1 cycle → debug_addr=5 gives debug_data=0x00000000; read_addr_a=5 gives 0.
- Write/read: write_en=1, write_addr=8, write_data=0x00001234, clock; next cycle read_addr_a=8, read_addr_b=8 → both 0x00001234.
- r0 hardwired: write_en=1, write_addr=0, write_data=0xFFFFFFFF → read_data_a=0 during the cycle and after the edge; debug_data(0)=0.
- Bypass: r3 holds 0x11; present write_en=1, write_addr=3, write_data=0x22 with read_addr_a=3, read_addr_b=4 → read_data_a=0x22 pre-edge, read_data_b=entry4. With write_en=0 and the same data, read_data_a=0x11.
- Reset priority: rst=1, write_en=1, write_addr=9, write_data=0x55 → read ports 0 during the cycle; after the edge debug_data(9)=0.
- ALU pairing: r1=7, r2=5 feed the ALU (sub) → result 2 written back to r4 with write_en=1 → next cycle read_addr_a=4 gives 0x00000002; ALU zero_flag=0.
